// File: rtl/avst_cmd_to_avmm_bridge.sv
// Avalon-ST command stream to Avalon-MM master bridge. Holds one command, issues it
// in stream order, and returns read data through a credit-limited show-ahead response FIFO.
module avst_cmd_to_avmm_bridge #(
  parameter int AVMM_ADDR_WIDTH = 48,
  parameter int AVMM_DATA_WIDTH = 512,
  parameter int RSP_FIFO_DEPTH  = 8,
  localparam int CMD_WIDTH      = AVMM_ADDR_WIDTH + AVMM_DATA_WIDTH + 1,
  localparam int CNT_WIDTH      = $clog2(RSP_FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [CMD_WIDTH-1:0]         avst_avcmd_data,
  input  logic                         avst_avcmd_valid,
  output logic                         avst_avcmd_ready,
  output logic [AVMM_ADDR_WIDTH-1:0]   avmm_address,
  output logic [AVMM_DATA_WIDTH-1:0]   avmm_writedata,
  output logic [AVMM_DATA_WIDTH/8-1:0] avmm_byteenable,
  output logic                         avmm_read,
  output logic                         avmm_write,
  input  logic                         avmm_waitrequest,
  input  logic [AVMM_DATA_WIDTH-1:0]   avmm_readdata,
  input  logic                         avmm_readdatavalid,
  output logic [AVMM_DATA_WIDTH-1:0]   avst_rd_rsp_data,
  output logic                         avst_rd_rsp_valid,
  input  logic                         avst_rd_rsp_ready,
  output logic [CNT_WIDTH-1:0]         rd_credits,
  output logic                         err_unsolicited
);
  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);

  logic                 cmd_valid;
  logic                 cmd_is_read;
  logic                 issue;
  logic                 rd_issue;
  logic                 cmd_acc;
  logic                 rsp_pop;
  logic                 rsp_push;
  logic                 fifo_full;
  logic [CNT_WIDTH-1:0] wr_ptr;
  logic [CNT_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] fifo_cnt;
  logic [AVMM_DATA_WIDTH-1:0] mem [RSP_FIFO_DEPTH];

  // A read without a credit waits in the register, which also blocks younger writes.
  assign avmm_write       = cmd_valid & ~cmd_is_read;
  assign avmm_read        = cmd_valid & cmd_is_read & (rd_credits != '0);
  assign issue            = (avmm_read | avmm_write) & ~avmm_waitrequest;
  assign rd_issue         = avmm_read & ~avmm_waitrequest;
  assign avst_avcmd_ready = ~cmd_valid | issue;
  assign cmd_acc          = avst_avcmd_valid & avst_avcmd_ready;
  assign avmm_byteenable  = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid      <= 1'b0;
      cmd_is_read    <= 1'b0;
      avmm_address   <= '0;
      avmm_writedata <= '0;
    end else if (cmd_acc) begin
      cmd_valid      <= 1'b1;
      cmd_is_read    <= avst_avcmd_data[0];
      avmm_address   <= avst_avcmd_data[CMD_WIDTH-1 -: AVMM_ADDR_WIDTH];
      avmm_writedata <= avst_avcmd_data[AVMM_DATA_WIDTH:1];
    end else if (issue) begin
      cmd_valid      <= 1'b0;
    end
  end

  // A credit is held from read issue until its response leaves the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_credits <= CNT_WIDTH'(RSP_FIFO_DEPTH);
    end else begin
      case ({rd_issue, rsp_pop})
        2'b10:   rd_credits <= rd_credits - CNT_WIDTH'(1);
        2'b01:   rd_credits <= rd_credits + CNT_WIDTH'(1);
        default: rd_credits <= rd_credits;
      endcase
    end
  end

  assign fifo_cnt          = wr_ptr - rd_ptr;
  assign fifo_full         = (fifo_cnt == CNT_WIDTH'(RSP_FIFO_DEPTH));
  assign avst_rd_rsp_valid = (wr_ptr != rd_ptr);
  assign avst_rd_rsp_data  = mem[rd_ptr[PTR_W-1:0]];
  assign rsp_pop           = avst_rd_rsp_valid & avst_rd_rsp_ready;
  assign rsp_push          = avmm_readdatavalid & ~fifo_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      err_unsolicited <= 1'b0;
    end else begin
      if (rsp_push) wr_ptr <= wr_ptr + CNT_WIDTH'(1);
      if (rsp_pop)  rd_ptr <= rd_ptr + CNT_WIDTH'(1);
      if (avmm_readdatavalid & fifo_full) err_unsolicited <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_push) mem[wr_ptr[PTR_W-1:0]] <= avmm_readdata;
  end
endmodule

// File: tb/tb_avst_cmd_to_avmm_bridge.sv
// Directed bench for avst_cmd_to_avmm_bridge with a 2-cycle-latency slave model
// and monitors recording issued AVMM transfers and popped responses.
module tb_avst_cmd_to_avmm_bridge;
  localparam int AW = 48;
  localparam int DW = 512;
  localparam int CW = AW + DW + 1;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [CW-1:0] cmd_data = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] avmm_address;
  logic [DW-1:0] avmm_writedata;
  logic [DW/8-1:0] avmm_byteenable;
  logic          avmm_read, avmm_write;
  logic          avmm_waitrequest;
  logic [DW-1:0] avmm_readdata;
  logic          avmm_readdatavalid;
  logic [DW-1:0] rsp_data;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [3:0]    rd_credits;
  logic          err_unsolicited;

  logic          wr_force = 1'b0, rand_wr = 1'b0, wr_rand = 1'b0;
  logic          force_rdv = 1'b0;
  logic [DW-1:0] force_data = '0;
  logic          s1_v, s2_v;
  logic [DW-1:0] s1_d, s2_d;
  txn_t          log_q[$];
  logic [DW-1:0] rsp_q[$];
  int            checks = 0, errors = 0;

  logic [DW-1:0] D1, D2, D3, DA, DB;

  always #5 clk = ~clk;

  avst_cmd_to_avmm_bridge dut (
    .clk(clk), .reset_n(reset_n),
    .avst_avcmd_data(cmd_data), .avst_avcmd_valid(cmd_valid), .avst_avcmd_ready(cmd_ready),
    .avmm_address(avmm_address), .avmm_writedata(avmm_writedata),
    .avmm_byteenable(avmm_byteenable), .avmm_read(avmm_read), .avmm_write(avmm_write),
    .avmm_waitrequest(avmm_waitrequest), .avmm_readdata(avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid),
    .avst_rd_rsp_data(rsp_data), .avst_rd_rsp_valid(rsp_valid), .avst_rd_rsp_ready(rsp_ready),
    .rd_credits(rd_credits), .err_unsolicited(err_unsolicited)
  );

  function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
    return {16{~a[31:0]}};
  endfunction

  assign avmm_waitrequest   = rand_wr ? wr_rand : wr_force;
  assign avmm_readdatavalid = s2_v | force_rdv;
  assign avmm_readdata      = force_rdv ? force_data : s2_d;

  always @(posedge clk) wr_rand <= 1'($urandom_range(0, 1));

  // Slave returns read data two cycles after the read is accepted.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_d <= '0; s2_d <= '0;
    end else begin
      s1_v <= avmm_read & ~avmm_waitrequest;
      s1_d <= rd_of(avmm_address);
      s2_v <= s1_v;
      s2_d <= s1_d;
    end
  end

  always @(posedge clk) begin
    if (reset_n && (avmm_read || avmm_write) && !avmm_waitrequest)
      log_q.push_back('{wr: avmm_write, a: avmm_address, d: avmm_writedata});
    if (reset_n && rsp_valid && rsp_ready)
      rsp_q.push_back(rsp_data);
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_data  = {a, d, rd};
    cmd_valid = 1'b1;
  endtask

  // Ticks n cycles, dropping cmd_valid once the presented command is accepted.
  task automatic run(input int n);
    logic r;
    for (int i = 0; i < n; i++) begin
      #1; r = cmd_ready;
      tick();
      if (r) cmd_valid = 1'b0;
    end
  endtask

  task automatic send(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic r;
    int   n;
    put(rd, a, d);
    n = 0;
    forever begin
      #1; r = cmd_ready;
      tick();
      if (r) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $error("FAIL send_timeout observed no accept expected accept addr %0h", a);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    D1 = {64{8'hA5}}; D2 = {64{8'h3C}}; D3 = {32{16'h1234}};
    DA = {16{32'hDEAD_0001}}; DB = {16{32'hBEEF_0002}};

    // Reset state
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read", DW'(avmm_read), 0);
    chk("rst_write", DW'(avmm_write), 0);
    chk("rst_addr", DW'(avmm_address), 0);
    chk("rst_wdata", avmm_writedata, 0);
    chk("rst_rsp_valid", DW'(rsp_valid), 0);
    chk("rst_credits", DW'(rd_credits), 8);
    chk("rst_err", DW'(err_unsolicited), 0);
    chk("rst_byteen", DW'(avmm_byteenable), {64{1'b1}});
    reset_n = 1'b1;
    tick();

    // 1: single write
    log_q.delete();
    put(1'b0, 48'h100, D1);
    #1 chk("t1_ready_idle", DW'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    chk("t1_write", DW'(avmm_write), 1);
    chk("t1_read", DW'(avmm_read), 0);
    chk("t1_addr", DW'(avmm_address), 48'h100);
    chk("t1_wdata", avmm_writedata, D1);
    chk("t1_ready_issue", DW'(cmd_ready), 1);
    tick();
    chk("t1_write_done", DW'(avmm_write), 0);
    chk("t1_log_n", DW'(log_q.size()), 1);
    chk("t1_log_a", DW'(log_q[0].a), 48'h100);

    // 2: write held under waitrequest, next command accepted on issue
    log_q.delete();
    wr_force = 1'b1;
    put(1'b0, 48'h200, D2);
    tick();
    put(1'b0, 48'h204, D3);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_hold_write", DW'(avmm_write), 1);
      chk("t2_hold_addr", DW'(avmm_address), 48'h200);
      chk("t2_hold_data", avmm_writedata, D2);
      chk("t2_hold_ready", DW'(cmd_ready), 0);
      tick();
    end
    wr_force = 1'b0;
    #1 chk("t2_ready_on_issue", DW'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    chk("t2_next_write", DW'(avmm_write), 1);
    chk("t2_next_addr", DW'(avmm_address), 48'h204);
    tick();
    chk("t2_log_n", DW'(log_q.size()), 2);
    chk("t2_log0", DW'(log_q[0].a), 48'h200);
    chk("t2_log1", DW'(log_q[1].a), 48'h204);
    chk("t2_log1_d", log_q[1].d, D3);

    // 3: DEPTH+2 reads with responses held back
    log_q.delete(); rsp_q.delete();
    for (int i = 0; i < 9; i++) send(1'b1, 48'h1000 + 48'(i), '0);
    put(1'b1, 48'h1009, '0);
    run(10);
    chk("t3_credits0", DW'(rd_credits), 0);
    chk("t3_stalled_ready", DW'(cmd_ready), 0);
    chk("t3_no_read", DW'(avmm_read), 0);
    chk("t3_issued8", DW'(log_q.size()), 8);
    chk("t3_rsp_valid", DW'(rsp_valid), 1);
    rsp_ready = 1'b1;
    run(40);
    chk("t3_issued10", DW'(log_q.size()), 10);
    chk("t3_rsp_n", DW'(rsp_q.size()), 10);
    for (int i = 0; i < 10; i++) begin
      chk("t3_log_addr", DW'(log_q[i].a), DW'(48'h1000 + 48'(i)));
      chk("t3_rsp_data", rsp_q[i], rd_of(48'h1000 + 48'(i)));
    end
    chk("t3_credits8", DW'(rd_credits), 8);

    // 4: interleaved W,R,W,R under random waitrequest
    log_q.delete(); rsp_q.delete();
    rand_wr = 1'b1;
    send(1'b0, 48'h300, DA);
    send(1'b1, 48'h304, '0);
    send(1'b0, 48'h308, DB);
    send(1'b1, 48'h30C, '0);
    run(30);
    rand_wr = 1'b0;
    chk("t4_log_n", DW'(log_q.size()), 4);
    chk("t4_op0", DW'({log_q[0].wr, log_q[0].a}), DW'({1'b1, 48'h300}));
    chk("t4_op0_d", log_q[0].d, DA);
    chk("t4_op1", DW'({log_q[1].wr, log_q[1].a}), DW'({1'b0, 48'h304}));
    chk("t4_op2", DW'({log_q[2].wr, log_q[2].a}), DW'({1'b1, 48'h308}));
    chk("t4_op2_d", log_q[2].d, DB);
    chk("t4_op3", DW'({log_q[3].wr, log_q[3].a}), DW'({1'b0, 48'h30C}));
    chk("t4_rsp_n", DW'(rsp_q.size()), 2);
    chk("t4_rsp0", rsp_q[0], rd_of(48'h304));
    chk("t4_rsp1", rsp_q[1], rd_of(48'h30C));

    // 5: pop and read issue together at one credit, then unsolicited data while full
    rsp_ready = 1'b0; rsp_q.delete();
    for (int i = 0; i < 7; i++) send(1'b1, 48'h500 + 48'(i), '0);
    run(6);
    chk("t5_credits1", DW'(rd_credits), 1);
    put(1'b1, 48'h507, '0);
    tick();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    #1 chk("t5_read_strobe", DW'(avmm_read), 1);
    tick();
    rsp_ready = 1'b0;
    chk("t5_credits_same", DW'(rd_credits), 1);
    run(5);
    send(1'b1, 48'h600, '0);
    run(5);
    chk("t5_credits_full", DW'(rd_credits), 0);
    chk("t5_err_before", DW'(err_unsolicited), 0);
    force_data = '1;
    force_rdv  = 1'b1;
    tick();
    force_rdv  = 1'b0;
    chk("t5_err_set", DW'(err_unsolicited), 1);
    chk("t5_head", rsp_data, rd_of(48'h501));
    rsp_q.delete();
    rsp_ready = 1'b1;
    run(12);
    chk("t5_rsp_n", DW'(rsp_q.size()), 8);
    for (int i = 0; i < 7; i++) chk("t5_rsp_data", rsp_q[i], rd_of(48'h501 + 48'(i)));
    chk("t5_rsp_last", rsp_q[7], rd_of(48'h600));
    chk("t5_credits8", DW'(rd_credits), 8);
    chk("t5_err_sticky", DW'(err_unsolicited), 1);

    // 6: reset with reads in flight and responses queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b1, 48'h700 + 48'(i), '0);
    run(1);
    chk("t6_credits3", DW'(rd_credits), 3);
    chk("t6_queued", DW'(rsp_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_credits", DW'(rd_credits), 8);
    chk("t6_rst_rsp_valid", DW'(rsp_valid), 0);
    chk("t6_rst_read", DW'(avmm_read), 0);
    chk("t6_rst_write", DW'(avmm_write), 0);
    chk("t6_rst_addr", DW'(avmm_address), 0);
    chk("t6_rst_err", DW'(err_unsolicited), 0);
    chk("t6_rst_ready", DW'(cmd_ready), 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    run(4);
    chk("t6_post_credits", DW'(rd_credits), 8);
    chk("t6_post_rsp_valid", DW'(rsp_valid), 0);
    chk("t6_post_read", DW'(avmm_read), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
